// File: rtl/reg_write_arbiter_if.sv
// Shared-register write port bundle: requester side inputs, registered write outputs.
interface reg_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_lock;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            grant;
   logic [WIDTH-1:0]              reg_input;
   logic                          reg_write;
   logic                          busy;

   modport master (
      output req, req_lock, req_data,
      input  grant, reg_input, reg_write, busy
   );

   modport slave (
      input  req, req_lock, req_data,
      output grant, reg_input, reg_write, busy
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for one shared register, with a bounded lock
// that lets a winner keep the port for up to LOCK_MAX consecutive writes.
module reg_write_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH    = 16,
   parameter int LOCK_MAX = 4
) (
   input logic                CLK,
   input logic                reset,
   reg_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(LOCK_MAX + 1);

   typedef enum logic {ARB, LOCKED} state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [CW-1:0] lock_cnt;

   // First set request at or above p, wrapping; MSB flags that one was found.
   function automatic logic [PW:0] pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] p);
      logic [PW:0] res;
      int          idx;
      res = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(p) + i) % NUM_REQ;
         if (!res[PW] && r[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   logic [PW:0]   pick_res;
   logic          found;
   logic [PW-1:0] win;
   logic [PW-1:0] win_nxt;
   logic          hold;

   // rr_ptr sits at owner+1 while locked, so plain arbitration on release
   // already ranks the old owner last.
   always_comb begin
      pick_res = pick(bus.req, rr_ptr);
      found    = pick_res[PW];
      win      = pick_res[PW-1:0];
      win_nxt  = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
      hold     = (state == LOCKED) && bus.req[owner] && bus.req_lock[owner] &&
                 (lock_cnt < CW'(LOCK_MAX));
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state         <= ARB;
         rr_ptr        <= '0;
         owner         <= '0;
         lock_cnt      <= '0;
         bus.grant     <= '0;
         bus.reg_input <= '0;
         bus.reg_write <= 1'b0;
         bus.busy      <= 1'b0;
      end else if (hold) begin
         bus.grant     <= NUM_REQ'(1) << owner;
         bus.reg_input <= bus.req_data[owner];
         bus.reg_write <= 1'b1;
         lock_cnt      <= lock_cnt + CW'(1);
      end else if (found) begin
         bus.grant     <= NUM_REQ'(1) << win;
         bus.reg_input <= bus.req_data[win];
         bus.reg_write <= 1'b1;
         rr_ptr        <= win_nxt;
         if (bus.req_lock[win] && (LOCK_MAX > 1)) begin
            state    <= LOCKED;
            owner    <= win;
            lock_cnt <= CW'(1);
            bus.busy <= 1'b1;
         end else begin
            state    <= ARB;
            lock_cnt <= '0;
            bus.busy <= 1'b0;
         end
      end else begin
         bus.grant     <= '0;
         bus.reg_write <= 1'b0;
         state         <= ARB;
         lock_cnt      <= '0;
         bus.busy      <= 1'b0;
      end
   end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing the write port of one WIDTH-bit Register (reg_input / reg_write / reset / CLK) among NUM_REQ requesters.
- Registers the winning requester's data and a one-cycle write strobe that drive the Register directly.
- Supports a bounded lock mode so a requester can perform back-to-back writes without starving the others.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, data width of the shared register
LOCK_MAX, 4, max consecutive granted writes one requester may hold under lock (>=1)

Ports:
CLK  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester write request, level
req_lock  input  NUM_REQ  per-requester lock request, only meaningful with req
req_data  input  NUM_REQ*WIDTH  packed data, requester i at bits [i*WIDTH +: WIDTH]
grant  output  NUM_REQ  registered one-hot grant, 0 when no write issued
reg_input  output  WIDTH  registered data to the shared Register
reg_write  output  1  registered write strobe to the shared Register
busy  output  1  high while in LOCKED state

Behaviour:
- Reset (async, immediate, also mid-lock): grant=0, reg_input=0, reg_write=0, busy=0, state=IDLE, rr_ptr=0, lock_cnt=0.
- Two states: ARB and LOCKED. IDLE is ARB with no request.
- Latency: req sampled at edge k. grant, reg_input and reg_write become valid after edge k. The Register captures at edge k+1. grant[i]=1 means requester i's data was taken at edge k.
- ARB, at each edge:
  - No req bit set: grant=0, reg_write=0, reg_input holds its previous value.
  - Otherwise the winner w is the first set req bit scanning from rr_ptr upward, wrapping NUM_REQ-1 to 0.
  - Outputs: grant=onehot(w), reg_input=req_data[w], reg_write=1.
  - rr_ptr = (w+1) mod NUM_REQ.
  - If req_lock[w]=1 and LOCK_MAX>1: go to LOCKED, lock_cnt=1.
- LOCKED, owner o, at each edge:
  - If req[o]=1, req_lock[o]=1 and lock_cnt<LOCK_MAX: grant=onehot(o), reg_input=req_data[o], reg_write=1, lock_cnt+1. rr_ptr is unchanged (still o+1).
  - Otherwise: return to ARB and arbitrate normally at this same edge. o is excluded if lock_cnt reached LOCK_MAX, so a different requester wins if any is pending. o wins only if it is the sole requester.
  - Other requesters' req bits are ignored while the lock holds.
- busy=1 exactly when state=LOCKED.
- Each granted cycle is exactly one write. A requester still asserting req after its grant is re-arbitrated, not auto-repeated, unless locked.
- req_lock without req is ignored. req_lock of a non-winner is ignored.
- Simultaneous requests from all requesters: service order follows rr_ptr. Each requester is served at most once per NUM_REQ granted cycles, except lock owners.
- grant is always one-hot or zero. reg_write equals OR of grant.
- Datapath width is purely parametric. No arithmetic beyond the rr_ptr wrap and lock_cnt, with lock_cnt sized to hold LOCK_MAX.

Test Plan:
1. Reset: assert reset mid-cycle with req=4'b1111 active → grant=0, reg_write=0, reg_input=16'h0000 immediately. After release and one edge with req=0, the Register still reads 0.
2. Single write: req=4'b0100, req_data[2]=16'h8888 for one cycle → next cycle grant=4'b0100, reg_write=1, reg_input=16'h8888. The cycle after, reg_write=0 and the Register output is 16'h8888 and persists for 10 cycles.
3. Round-robin fairness: req=4'b1111 held, distinct data 16'h1111/2222/3333/4444 → grants 0001, 0010, 0100, 1000, 0001 on successive cycles. The Register output follows the same data sequence one cycle later.
4. Wrap and skip: rr_ptr=3 (after a grant to requester 2), req=4'b0011 → grant 0001 then 0010, with no idle cycle between.
5. Lock bound: LOCK_MAX=4, req=4'b0011, req_lock=4'b0001 held → requester 0 gets 4 consecutive grants with busy=1. Requester 1 is granted on the 5th cycle and busy=0.
6. Lock release: requester 0 locked, req_lock[0] drops after 2 grants while req[1]=1 → the next grant is 4'b0010 and busy falls the same cycle.
